// File: rtl/path_tracer.sv
// path_tracer: walks the shortest-path predecessor table from Dst back to Src
// and streams every visited node, flagging unreachable or runaway chains.
module path_tracer #(
    parameter int                 A_WIDTH  = 13,
    parameter int                 D_WIDTH  = 8,
    parameter int                 MAX_HOPS = 256,
    parameter logic [D_WIDTH-1:0] NO_PRED  = '1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic [D_WIDTH-1:0] Src,
    input  logic [D_WIDTH-1:0] Dst,
    input  logic [D_WIDTH-1:0] P_In,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               P_En,
    output logic               P_Rw,
    output logic [D_WIDTH-1:0] Node_Out,
    output logic               Node_Valid,
    input  logic               Node_Ready,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [15:0]        Length
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_READ,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [15:0] HOP_LIMIT = 16'(MAX_HOPS);

    state_t             state;
    logic [D_WIDTH-1:0] src_q;
    logic [D_WIDTH-1:0] cur;
    logic [15:0]        hop_cnt;

    logic [15:0]        hop_nxt;
    logic               at_src;
    logic               at_limit;
    logic               no_pred;

    // P is read-only from this block
    assign P_Rw = 1'b1;

    // Decisions taken when the current node is handed off or P data returns
    always_comb begin
        hop_nxt  = hop_cnt + 16'd1;
        at_src   = (cur == src_q);
        at_limit = (hop_nxt == HOP_LIMIT);
        no_pred  = (P_In == NO_PRED);
    end

    // Walk controller: emit, look up predecessor, repeat until Src or error
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= S_IDLE;
            src_q      <= '0;
            cur        <= '0;
            hop_cnt    <= '0;
            P_Addr     <= '0;
            P_En       <= 1'b0;
            Node_Out   <= '0;
            Node_Valid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            Length     <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Go) begin
                        src_q      <= Src;
                        cur        <= Dst;
                        Node_Out   <= Dst;
                        Node_Valid <= 1'b1;
                        hop_cnt    <= '0;
                        Length     <= '0;
                        Err        <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (Node_Ready) begin
                        Node_Valid <= 1'b0;
                        Length     <= Length + 16'd1;
                        hop_cnt    <= hop_nxt;
                        if (at_src) begin
                            Done  <= 1'b1;
                            state <= S_FIN;
                        end else if (at_limit) begin
                            Err   <= 1'b1;
                            Done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            P_En   <= 1'b1;
                            P_Addr <= A_WIDTH'(cur);
                            state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    P_En  <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (no_pred) begin
                        Err   <= 1'b1;
                        Done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        cur        <= P_In;
                        Node_Out   <= P_In;
                        Node_Valid <= 1'b1;
                        state      <= S_EMIT;
                    end
                end
                S_FIN: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_tracer.sv
// tb_path_tracer: directed and randomized walks over a modelled P SRAM,
// checked against a list-based reference walk.
module tb_path_tracer;

    localparam int MAXH = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Go = 1'b0;
    logic [7:0]  Src = '0;
    logic [7:0]  Dst = '0;
    logic [7:0]  P_In = '0;
    logic [12:0] P_Addr;
    logic        P_En;
    logic        P_Rw;
    logic [7:0]  Node_Out;
    logic        Node_Valid;
    logic        Node_Ready = 1'b1;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] Length;

    path_tracer #(
        .A_WIDTH (13),
        .D_WIDTH (8),
        .MAX_HOPS(MAXH),
        .NO_PRED (8'hFF)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Go        (Go),
        .Src       (Src),
        .Dst       (Dst),
        .P_In      (P_In),
        .P_Addr    (P_Addr),
        .P_En      (P_En),
        .P_Rw      (P_Rw),
        .Node_Out  (Node_Out),
        .Node_Valid(Node_Valid),
        .Node_Ready(Node_Ready),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Length    (Length)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // synchronous P SRAM
    logic [7:0] mem [256];
    always @(posedge Clk) if (P_En) P_In <= mem[P_Addr[7:0]];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // observed walk
    logic [7:0]  q_nodes [$];
    int          q_vcyc  [$];
    logic [12:0] q_reads [$];
    int          go_cyc, fv_cyc, done_cyc, done_n;
    logic        done_err;
    logic [15:0] done_len;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0]  prev_out = '0;

    always @(negedge Clk) begin
        if (Rst && prev_v && !prev_r) begin
            check("stall_valid", {31'd0, Node_Valid}, 32'd1);
            check("stall_hold", {24'd0, Node_Out}, {24'd0, prev_out});
            check("stall_no_read", {31'd0, P_En}, 32'd0);
        end
        prev_v   = Node_Valid;
        prev_r   = Node_Ready;
        prev_out = Node_Out;
        if (Rst && Go && !Busy) begin
            go_cyc = cyc;
            fv_cyc = -1;
            done_n = 0;
            q_nodes.delete();
            q_vcyc.delete();
            q_reads.delete();
        end
        if (Node_Valid && fv_cyc < 0) fv_cyc = cyc;
        if (Node_Valid && Node_Ready) begin
            q_nodes.push_back(Node_Out);
            q_vcyc.push_back(cyc);
        end
        if (P_En) q_reads.push_back(P_Addr);
        if (Done) begin
            done_n++;
            done_cyc = cyc;
            done_err = Err;
            done_len = Length;
        end
    end

    // reference walk: list of nodes, list of lookups, how it ended
    logic [7:0] m_nodes [$];
    logic [7:0] m_reads [$];
    int         m_kind;   // 0 reached Src, 1 hop limit, 2 no predecessor

    task automatic model_walk(input logic [7:0] s, input logic [7:0] d);
        logic [7:0] c;
        m_nodes.delete();
        m_reads.delete();
        c = d;
        forever begin
            m_nodes.push_back(c);
            if (c == s) begin m_kind = 0; break; end
            if (m_nodes.size() == MAXH) begin m_kind = 1; break; end
            m_reads.push_back(c);
            if (mem[c] == 8'hFF) begin m_kind = 2; break; end
            c = mem[c];
        end
    endtask

    task automatic start_walk(input logic [7:0] s, input logic [7:0] d);
        @(posedge Clk); #1;
        Src = s;
        Dst = d;
        Go  = 1'b1;
        @(posedge Clk); #1;
        Go  = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 3000; i++) begin
            if (done_n > 0) break;
            @(posedge Clk); #1;
            Node_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (done_n == 0) check("done_timeout", 32'd0, 32'd1);
        Node_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic chk_walk(input string nm, input logic [7:0] s,
                            input logic [7:0] d, input bit tim);
        int n, exp_done;
        model_walk(s, d);
        n = m_nodes.size();
        check({nm, "_done_cnt"}, done_n, 32'd1);
        check({nm, "_len"}, {16'd0, done_len}, n);
        check({nm, "_err"}, {31'd0, done_err}, {31'd0, m_kind != 0});
        check({nm, "_n_nodes"}, q_nodes.size(), n);
        for (int i = 0; i < n && i < q_nodes.size(); i++)
            check($sformatf("%s_node%0d", nm, i), {24'd0, q_nodes[i]},
                  {24'd0, m_nodes[i]});
        check({nm, "_n_reads"}, q_reads.size(), m_reads.size());
        for (int i = 0; i < m_reads.size() && i < q_reads.size(); i++)
            check($sformatf("%s_read%0d", nm, i), {19'd0, q_reads[i]},
                  {24'd0, m_reads[i]});
        if (tim) begin
            check({nm, "_first_valid"}, fv_cyc, go_cyc + 1);
            for (int i = 0; i < q_vcyc.size(); i++)
                check($sformatf("%s_vcyc%0d", nm, i), q_vcyc[i],
                      fv_cyc + 3 * i);
            exp_done = fv_cyc + 3 * (n - 1) + ((m_kind == 2) ? 3 : 1);
            check({nm, "_done_cyc"}, done_cyc, exp_done);
        end
    endtask

    task automatic reset_outs(input string nm);
        check({nm, "_valid"}, {31'd0, Node_Valid}, 32'd0);
        check({nm, "_out"}, {24'd0, Node_Out}, 32'd0);
        check({nm, "_pen"}, {31'd0, P_En}, 32'd0);
        check({nm, "_paddr"}, {19'd0, P_Addr}, 32'd0);
        check({nm, "_done"}, {31'd0, Done}, 32'd0);
        check({nm, "_err"}, {31'd0, Err}, 32'd0);
        check({nm, "_busy"}, {31'd0, Busy}, 32'd0);
        check({nm, "_len"}, {16'd0, Length}, 32'd0);
        check({nm, "_rw"}, {31'd0, P_Rw}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        fv_cyc = -1;
        done_n = 0;
        #23;
        reset_outs("rst");
        @(posedge Clk); #1;
        Rst = 1'b1;

        // basic three-node chain
        mem[5] = 8'd3;
        mem[3] = 8'd1;
        start_walk(8'd1, 8'd5);
        wait_done(1'b0);
        chk_walk("chain", 8'd1, 8'd5, 1'b1);
        check("chain_busy_after", {31'd0, Busy}, 32'd0);

        // single node walk
        start_walk(8'd7, 8'd7);
        wait_done(1'b0);
        chk_walk("single", 8'd7, 8'd7, 1'b1);

        // unreachable destination, Err held afterwards
        start_walk(8'd0, 8'd9);
        wait_done(1'b0);
        chk_walk("nopred", 8'd0, 8'd9, 1'b1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("err_hold", {31'd0, Err}, 32'd1);
        check("len_hold", {16'd0, Length}, 32'd1);

        // two-node cycle hits the hop limit
        mem[4] = 8'd6;
        mem[6] = 8'd4;
        start_walk(8'd0, 8'd4);
        @(negedge Clk);
        check("err_clr", {31'd0, Err}, 32'd0);
        check("len_clr", {16'd0, Length}, 32'd0);
        wait_done(1'b0);
        chk_walk("loop", 8'd0, 8'd4, 1'b1);

        // backpressure on second node, stray Go ignored
        start_walk(8'd1, 8'd5);
        for (int i = 0; i < 20 && q_nodes.size() == 0; i++) @(negedge Clk);
        @(posedge Clk); #1;
        Node_Ready = 1'b0;
        for (int i = 0; i < 20 && !Node_Valid; i++) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge Clk); #1;
            end
            if (i == 2) begin Go = 1'b1; Src = 8'd9; Dst = 8'd9; end
            if (i == 3) Go = 1'b0;
            @(negedge Clk);
            check($sformatf("bp_out%0d", i), {24'd0, Node_Out}, 32'd3);
            check($sformatf("bp_valid%0d", i), {31'd0, Node_Valid}, 32'd1);
            check($sformatf("bp_pen%0d", i), {31'd0, P_En}, 32'd0);
            check($sformatf("bp_busy%0d", i), {31'd0, Busy}, 32'd1);
        end
        @(posedge Clk); #1;
        Node_Ready = 1'b1;
        wait_done(1'b0);
        chk_walk("bp", 8'd1, 8'd5, 1'b0);

        // reset in WAIT aborts the walk
        start_walk(8'd1, 8'd5);
        for (int i = 0; i < 20 && !P_En; i++) @(negedge Clk);
        @(posedge Clk); #2;
        Rst = 1'b0;
        #1;
        reset_outs("arst");
        done_n = 0;
        repeat (4) @(posedge Clk);
        #1;
        check("arst_no_done", done_n, 32'd0);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("arst_idle", {31'd0, Busy}, 32'd0);
        start_walk(8'd1, 8'd5);
        wait_done(1'b0);
        chk_walk("rerun", 8'd1, 8'd5, 1'b1);

        // randomized forests with occasional cycles and dead ends
        for (int t = 0; t < 40; t++) begin
            logic [7:0] s, d;
            bit rnd;
            if (t % 8 == 0) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
                for (int i = 1; i < 48; i++) begin
                    case ($urandom_range(0, 9))
                        0:       mem[i] = 8'hFF;
                        1:       mem[i] = 8'($urandom_range(0, 47));
                        default: mem[i] = 8'($urandom_range(0, i - 1));
                    endcase
                end
            end
            d = 8'($urandom_range(0, 47));
            s = (t % 3 == 0) ? 8'($urandom_range(0, 47)) : 8'd0;
            rnd = t[0];
            start_walk(s, d);
            wait_done(rnd);
            chk_walk($sformatf("rnd%0d", t), s, d, !rnd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
